// File: rtl/mmult_sched_pkg.sv
// mmult_sched_pkg: shared types and the cyclic round-robin pick for the mmult_accel scheduler
package mmult_sched_pkg;
  localparam int MAX_REQ = 16;
  localparam int IDX_W = 4;
  typedef enum logic [2:0] {IDLE, START, RUN, DONE, DRAIN} sched_state_e;
  // first set bit of r at or after p, wrapping at n; 0 when r is empty
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] r, input logic [IDX_W-1:0] p, input int n);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(p) + i) % n;
      if (i < n && r[j[IDX_W-1:0]]) w = j[IDX_W-1:0];
    end
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner (one-hot and index) from req and a start pointer
//   req  in   N       request vector
//   ptr  in   IDX_W   highest-priority position
//   gnt  out  N       one-hot winner, 0 when req is empty
//   idx  out  IDX_W   winner index
module rr_arbiter
  import mmult_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = rr_pick(MAX_REQ'(req), ptr, N);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mmult_accel_scheduler.sv
// mmult_accel_scheduler: round-robin sharing of one ap_ctrl_hs accelerator with latency, job count and watchdog
//   clock, reset                 single clock, synchronous active-high reset
//   req/gnt/job_done             per-requester request, held grant, end-of-job pulse
//   job_timeout                  watchdog abort flag, coincident with job_done
//   job_cycles, jobs_completed   last job latency, normal-completion count
//   busy                         not IDLE
//   ap_start/ap_ready/ap_done/ap_idle  accelerator handshake
module mmult_accel_scheduler
  import mmult_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] job_done,
  output logic               job_timeout,
  output logic [CNT_W-1:0]   job_cycles,
  output logic [CNT_W-1:0]   jobs_completed,
  output logic               busy,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_idle
);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  sched_state_e state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, win_q, win_d, arb_idx, nxt_ptr;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, job_done_q, job_done_d, arb_gnt;
  logic job_timeout_q, job_timeout_d, ap_start_q, ap_start_d, active, wd_hit, fin;
  logic [CNT_W-1:0] cnt_q, cnt_d, job_cycles_q, job_cycles_d, jobs_q, jobs_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );
  always_comb begin
    active = state_q == START || state_q == RUN;
    // ap_done in the limit cycle still counts as a normal completion
    wd_hit = TIMEOUT_CYCLES > 0 && active && !ap_done && cnt_q == CNT_W'(TIMEOUT_CYCLES);
    // in START a finish needs ap_ready alongside ap_done
    fin = active && ap_done && (state_q == RUN || ap_ready);
    nxt_ptr = win_q == IDX_W'(NUM_REQ - 1) ? '0 : win_q + 1'b1;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d = win_q;
    gnt_d = gnt_q;
    job_done_d = '0;
    job_timeout_d = 1'b0;
    ap_start_d = ap_start_q;
    cnt_d = active ? (cnt_q == CNT_SAT ? cnt_q : cnt_q + 1'b1) : cnt_q;
    job_cycles_d = job_cycles_q;
    jobs_d = jobs_q;
    if (state_q == IDLE && |req) begin
      state_d = START;
      win_d = arb_idx;
      gnt_d = arb_gnt;
      ap_start_d = 1'b1;
      cnt_d = CNT_W'(1);
    end else if (wd_hit || fin) begin
      state_d = wd_hit ? DRAIN : DONE;
      ap_start_d = 1'b0;
      job_done_d = gnt_q;
      job_timeout_d = wd_hit;
      job_cycles_d = cnt_q;
      jobs_d = wd_hit ? jobs_q : jobs_q + 1'b1;
      gnt_d = '0;
      rr_ptr_d = nxt_ptr;
    end else if (state_q == START && ap_ready) begin
      state_d = RUN;
      ap_start_d = 1'b0;
    end else if (state_q == DONE || (state_q == DRAIN && ap_idle)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      job_done_q <= '0;
      job_timeout_q <= 1'b0;
      ap_start_q <= 1'b0;
      cnt_q <= '0;
      job_cycles_q <= '0;
      jobs_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q <= win_d;
      gnt_q <= gnt_d;
      job_done_q <= job_done_d;
      job_timeout_q <= job_timeout_d;
      ap_start_q <= ap_start_d;
      cnt_q <= cnt_d;
      job_cycles_q <= job_cycles_d;
      jobs_q <= jobs_d;
    end
  end
  assign gnt = gnt_q;
  assign job_done = job_done_q;
  assign job_timeout = job_timeout_q;
  assign job_cycles = job_cycles_q;
  assign jobs_completed = jobs_q;
  assign busy = state_q != IDLE;
  assign ap_start = ap_start_q;
endmodule

// File: tb/tb_mmult_accel_scheduler.sv
// tb_mmult_accel_scheduler: scoreboard bench for two scheduler builds (4-bit counters / 8-cycle watchdog)
module tb_mmult_accel_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [3:0] req_s[2], gnt_s[2], jd_s[2];
  logic jt_s[2], busy_s[2], st_s[2], rdy_s[2], done_s[2], idle_s[2];
  logic [3:0] jc_a, jn_a;
  logic [31:0] jc_b, jn_b;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [3:0] oh; logic [31:0] cyc; logic to; logic [31:0] jobs;} exp_t;
  exp_t q0[$], q1[$];
  int ptr_m[2], cnt_m[2], last_done[2];

  mmult_accel_scheduler #(.NUM_REQ(4), .CNT_W(4), .TIMEOUT_CYCLES(0)) u_a (
    .clock(clk), .reset(rst), .req(req_s[0]), .gnt(gnt_s[0]), .job_done(jd_s[0]),
    .job_timeout(jt_s[0]), .job_cycles(jc_a), .jobs_completed(jn_a), .busy(busy_s[0]),
    .ap_start(st_s[0]), .ap_ready(rdy_s[0]), .ap_done(done_s[0]), .ap_idle(idle_s[0]));
  mmult_accel_scheduler #(.NUM_REQ(4), .CNT_W(32), .TIMEOUT_CYCLES(8)) u_b (
    .clock(clk), .reset(rst), .req(req_s[1]), .gnt(gnt_s[1]), .job_done(jd_s[1]),
    .job_timeout(jt_s[1]), .job_cycles(jc_b), .jobs_completed(jn_b), .busy(busy_s[1]),
    .ap_start(st_s[1]), .ap_ready(rdy_s[1]), .ap_done(done_s[1]), .ap_idle(idle_s[1]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    step;
    for (int s = 0; s < 2; s++) begin
      logic [31:0] jc, jn;
      exp_t e;
      jc = s == 0 ? {28'b0, jc_a} : jc_b;
      jn = s == 0 ? {28'b0, jn_a} : jn_b;
      if (jd_s[s] != 0) begin
        if ((s == 0 ? q0.size() : q1.size()) == 0) chk("unexpected job_done", {28'b0, jd_s[s]}, 32'd0);
        else begin
          e = s == 0 ? q0.pop_front() : q1.pop_front();
          chk("job_done", {28'b0, jd_s[s]}, {28'b0, e.oh});
          chk("job_cycles", jc, e.cyc);
          chk("job_timeout", {31'b0, jt_s[s]}, {31'b0, e.to});
          chk("jobs_completed", jn, e.jobs);
        end
      end else if (jt_s[s]) chk("lone job_timeout", {31'b0, jt_s[s]}, 32'd0);
    end
  end

  // one job: accelerator raises ap_ready r cycles and ap_done d cycles after grant
  task automatic run_job(input int s, input logic [3:0] v, input int r, input int d, input bit gap, input int idle_n);
    int w, kmax, n, starts, sat;
    bit to, leak;
    exp_t e;
    step;
    req_s[s] = v;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr_m[s] + i) % 4;
      if (w < 0 && ((v >> j) & 4'd1) != 0) w = j;
    end
    sat = s == 0 ? 15 : 32'h7fffffff;
    to = s == 1 && d >= 8;
    kmax = to ? 7 : d;
    e.oh = 4'(1 << w);
    e.cyc = to ? 32'd8 : (d + 1 > sat ? sat : d + 1);
    e.to = to;
    if (!to) cnt_m[s]++;
    e.jobs = s == 0 ? cnt_m[s] % 16 : cnt_m[s];
    ptr_m[s] = (w + 1) % 4;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    do begin step; n++; end while (gnt_s[s] == 0 && n < 50);
    chk("gnt", {28'b0, gnt_s[s]}, {28'b0, e.oh});
    if (gnt_s[s] == 0) return;
    if (gap) chk("done-to-start gap", cyc - last_done[s] - 1, 32'd2);
    req_s[s] = 4'd0;
    idle_s[s] = 1'b0;
    starts = 0;
    for (int k = 0; k <= kmax; k++) begin
      rdy_s[s] = k == r;
      done_s[s] = k == d;
      starts += int'(st_s[s]);
      step;
    end
    rdy_s[s] = 1'b0;
    done_s[s] = 1'b0;
    starts += int'(st_s[s]);
    last_done[s] = cyc - 1;
    chk("ap_start cycles", starts, (r <= kmax ? r : kmax) + 1);
    if (to) begin
      leak = 1'b0;
      for (int i = 0; i < idle_n; i++) begin
        done_s[s] = 1'($urandom % 2);
        step;
        leak |= gnt_s[s] != 0 || !busy_s[s];
      end
      done_s[s] = 1'b0;
      chk("drain hold", {31'b0, leak}, 32'd0);
      idle_s[s] = 1'b1;
      step;
      chk("drain exit", {31'b0, busy_s[s]}, 32'd0);
    end
    idle_s[s] = 1'b1;
  endtask

  task automatic chk_zero(input int s);
    chk("rst gnt", {28'b0, gnt_s[s]}, 32'd0);
    chk("rst job_done", {28'b0, jd_s[s]}, 32'd0);
    chk("rst job_timeout", {31'b0, jt_s[s]}, 32'd0);
    chk("rst busy", {31'b0, busy_s[s]}, 32'd0);
    chk("rst ap_start", {31'b0, st_s[s]}, 32'd0);
    chk("rst job_cycles", s == 0 ? {28'b0, jc_a} : jc_b, 32'd0);
    chk("rst jobs_completed", s == 0 ? {28'b0, jn_a} : jn_b, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n, v, r, d;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_s[s] = 4'd0; rdy_s[s] = 1'b0; done_s[s] = 1'b0; idle_s[s] = 1'b1;
      ptr_m[s] = 0; cnt_m[s] = 0; last_done[s] = 0;
    end
    repeat (3) step;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_job(0, 4'hF, 1, 4, i > 0, 0);
    run_job(0, 4'b0001, 3, 10, 1'b0, 0);
    run_job(0, 4'b0010, 1, 1, 1'b0, 0);
    run_job(0, 4'b1000, 2, 20, 1'b0, 0);
    step;
    req_s[0] = 4'b0010;
    n = 0;
    do begin step; n++; end while (gnt_s[0] == 0 && n < 50);
    chk("abort job gnt", {31'b0, gnt_s[0] != 0}, 32'd1);
    req_s[0] = 4'd0;
    rdy_s[0] = 1'b1;
    step;
    rdy_s[0] = 1'b0;
    step;
    rst = 1'b1;
    step;
    chk_zero(0);
    rst = 1'b0;
    ptr_m = '{0, 0};
    cnt_m = '{0, 0};
    run_job(0, 4'b0100, 0, 3, 1'b0, 0);
    repeat (20) begin
      v = $urandom_range(1, 15);
      r = $urandom_range(0, 5);
      d = $urandom_range(0, 7) == 0 ? 18 : r + $urandom_range(0, 6);
      run_job(0, 4'(v), r, d, 1'b1, 0);
    end
    run_job(1, 4'b0001, 2, 1000, 1'b0, 5);
    run_job(1, 4'b0010, 3, 7, 1'b0, 0);
    repeat (15) begin
      v = $urandom_range(1, 15);
      r = $urandom_range(0, 9);
      d = r + $urandom_range(0, 5);
      run_job(1, 4'(v), r, d, 1'b0, $urandom_range(0, 4));
    end
    repeat (3) step;
    chk("scoreboard drained", q0.size() + q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
